// File: rtl/systolic_pe_db.sv
// Weight-stationary systolic PE with a double-buffered weight (shadow + active).
// Activations move west->east, partial sums move north->south, one register stage each.
// Supports INT8, single-lane INT4 and packed dual-INT4 dot product, plus optional
// saturating accumulation into a signed ACC_WIDTH partial sum.
module systolic_pe_db #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int SATURATE   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [1:0]            quantize_mode,
  input  logic [DATA_WIDTH-1:0] act_in,
  input  logic                  act_valid_in,
  input  logic [ACC_WIDTH-1:0]  psum_in,
  input  logic [DATA_WIDTH-1:0] weight_load_in,
  input  logic                  weight_load,
  input  logic                  weight_swap,
  output logic [DATA_WIDTH-1:0] act_out,
  output logic                  act_valid_out,
  output logic [ACC_WIDTH-1:0]  psum_out,
  output logic                  psum_valid_out,
  output logic                  shadow_full,
  output logic                  sat_flag
);
  localparam int H     = DATA_WIDTH / 2;
  localparam int PW    = 2 * DATA_WIDTH;
  localparam int AW1   = ACC_WIDTH + 1;
  localparam int LANES = 2;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} wbuf_t;

  wbuf_t                 state, state_nxt;
  logic [DATA_WIDTH-1:0] shadow, shadow_nxt;
  logic [DATA_WIDTH-1:0] active, active_nxt;

  // Weight buffer registers; not gated by enable so preload overlaps streaming.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= EMPTY;
      shadow <= '0;
      active <= '0;
    end else begin
      state  <= state_nxt;
      shadow <= shadow_nxt;
      active <= active_nxt;
    end
  end

  // Swap promotes the old shadow first, then a same-edge load refills it.
  always_comb begin
    state_nxt  = state;
    shadow_nxt = shadow;
    active_nxt = active;
    if (weight_swap && state == FULL) begin
      active_nxt = shadow;
      state_nxt  = EMPTY;
    end
    if (weight_load) begin
      shadow_nxt = weight_load_in;
      state_nxt  = FULL;
    end
  end

  assign shadow_full = (state == FULL);

  // Products: full-width INT8, and one signed INT4 product per lane.
  logic signed [PW-1:0] p_full;
  logic signed [PW-1:0] lane_p [LANES];
  logic signed [PW-1:0] prod;

  assign p_full = PW'($signed(active)) * PW'($signed(act_in));

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [PW-1:0] wl, al;
    assign wl        = PW'($signed(active[g*H +: H]));
    assign al        = PW'($signed(act_in[g*H +: H]));
    assign lane_p[g] = wl * al;
  end

  // Mode select for the product fed to the accumulator.
  always_comb begin
    prod = '0;
    case (quantize_mode)
      2'b00:   prod = p_full;
      2'b01:   prod = lane_p[0];
      2'b10:   prod = lane_p[0] + lane_p[1];
      default: prod = '0;
    endcase
  end

  // One guard bit catches signed overflow of the ACC_WIDTH sum.
  logic signed [AW1-1:0] sum;
  logic                  ovf;
  logic [ACC_WIDTH-1:0]  result;

  assign sum = AW1'($signed(psum_in)) + AW1'(prod);
  assign ovf = sum[AW1-1] ^ sum[AW1-2];

  // Clamp toward the sign of the true sum, or wrap when saturation is off.
  always_comb begin
    result = sum[ACC_WIDTH-1:0];
    if (ovf && SATURATE != 0) result = sum[AW1-1] ? ACC_MIN : ACC_MAX;
  end

  // Single-stage forwarding pipeline; enable=0 holds every output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_out        <= '0;
      act_valid_out  <= 1'b0;
      psum_out       <= '0;
      psum_valid_out <= 1'b0;
      sat_flag       <= 1'b0;
    end else if (enable) begin
      act_out        <= act_in;
      act_valid_out  <= act_valid_in;
      psum_valid_out <= act_valid_in;
      if (act_valid_in) begin
        psum_out <= result;
        sat_flag <= ovf;
      end else begin
        psum_out <= psum_in;
        sat_flag <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_systolic_pe_db.sv
// Bench for systolic_pe_db: a saturating and a wrapping instance share stimulus.
module tb_systolic_pe_db;
  logic        clk = 0;
  logic        rst_n, enable, act_valid_in, weight_load, weight_swap;
  logic [1:0]  quantize_mode;
  logic [7:0]  act_in, weight_load_in;
  logic [31:0] psum_in;
  logic [7:0]  ao_s, ao_w;
  logic        av_s, av_w, pv_s, pv_w, sf_s, sf_w, sat_s, sat_w;
  logic [31:0] ps_s, ps_w;

  always #5 clk = ~clk;

  systolic_pe_db #(.DATA_WIDTH(8), .ACC_WIDTH(32), .SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .enable(enable), .quantize_mode(quantize_mode),
    .act_in(act_in), .act_valid_in(act_valid_in), .psum_in(psum_in),
    .weight_load_in(weight_load_in), .weight_load(weight_load), .weight_swap(weight_swap),
    .act_out(ao_s), .act_valid_out(av_s), .psum_out(ps_s), .psum_valid_out(pv_s),
    .shadow_full(sf_s), .sat_flag(sat_s));

  systolic_pe_db #(.DATA_WIDTH(8), .ACC_WIDTH(32), .SATURATE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .enable(enable), .quantize_mode(quantize_mode),
    .act_in(act_in), .act_valid_in(act_valid_in), .psum_in(psum_in),
    .weight_load_in(weight_load_in), .weight_load(weight_load), .weight_swap(weight_swap),
    .act_out(ao_w), .act_valid_out(av_w), .psum_out(ps_w), .psum_valid_out(pv_w),
    .shadow_full(sf_w), .sat_flag(sat_w));

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  w, act;
    logic [31:0] psum;
    logic [31:0] e_sat;  logic f_sat;
    logic [31:0] e_wrap; logic f_wrap;
  } vec_t;

  typedef struct {
    logic [31:0] ps_s, ps_w;
    logic        pv, sf_s, sf_w;
    logic [7:0]  ao;
    logic        av;
  } exp_t;

  vec_t vecs[11];
  exp_t sbq[$];
  exp_t last;
  int   n_chk = 0, n_err = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  // Pop the oldest expected record and compare both instances against it.
  task automatic compare_out(input string nm);
    exp_t e;
    if (sbq.size() == 0) begin
      check({nm, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sbq.pop_front();
    last = e;
    check({nm, "_psum_sat"},  ps_s, e.ps_s);
    check({nm, "_psum_wrap"}, ps_w, e.ps_w);
    check({nm, "_pvld"},      {31'd0, pv_s}, {31'd0, e.pv});
    check({nm, "_pvld_w"},    {31'd0, pv_w}, {31'd0, e.pv});
    check({nm, "_satf"},      {31'd0, sat_s}, {31'd0, e.sf_s});
    check({nm, "_satf_w"},    {31'd0, sat_w}, {31'd0, e.sf_w});
    check({nm, "_act"},       {24'd0, ao_s}, {24'd0, e.ao});
    check({nm, "_avld"},      {31'd0, av_s}, {31'd0, e.av});
  endtask

  // Drive one compute cycle, push the expectation, advance, then score it.
  task automatic apply(input string nm, input logic [1:0] m, input logic [7:0] a,
                       input logic v, input logic [31:0] p,
                       input logic [31:0] es, input logic fs,
                       input logic [31:0] ew, input logic fw);
    exp_t e;
    quantize_mode = m; act_in = a; act_valid_in = v; psum_in = p;
    e.ps_s = es; e.ps_w = ew; e.pv = v; e.sf_s = fs; e.sf_w = fw; e.ao = a; e.av = v;
    sbq.push_back(e);
    @(posedge clk); #1;
    compare_out(nm);
  endtask

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    act_valid_in = 0; weight_load = 0; weight_swap = 0;
  endtask

  // Load then swap a weight so it becomes the active one.
  task automatic set_weight(input logic [7:0] w);
    idle();
    weight_load = 1; weight_load_in = w; cycle();
    weight_load = 0; weight_swap = 1; cycle();
    weight_swap = 0;
  endtask

  initial begin
    vecs[0]  = '{2'b00, 8'd2,   8'd10,  32'd0,        32'd20,       1'b0, 32'd20,       1'b0};
    vecs[1]  = '{2'b00, 8'hFD,  8'd4,   32'd0,        32'hFFFFFFF4, 1'b0, 32'hFFFFFFF4, 1'b0};
    vecs[2]  = '{2'b01, 8'h22,  8'h3D,  32'd0,        32'hFFFFFFFA, 1'b0, 32'hFFFFFFFA, 1'b0};
    vecs[3]  = '{2'b10, 8'h23,  8'hF2,  32'd0,        32'd4,        1'b0, 32'd4,        1'b0};
    vecs[4]  = '{2'b11, 8'h23,  8'h55,  32'd7,        32'd7,        1'b0, 32'd7,        1'b0};
    vecs[5]  = '{2'b00, 8'd127, 8'd127, 32'h7FFFFF00, 32'h7FFFFFFF, 1'b1, 32'h80003E01, 1'b1};
    vecs[6]  = '{2'b00, 8'h80,  8'd127, 32'h80000000, 32'h80000000, 1'b1, 32'h7FFFC080, 1'b1};
    vecs[7]  = '{2'b00, 8'h80,  8'h80,  32'd0,        32'h00004000, 1'b0, 32'h00004000, 1'b0};
    vecs[8]  = '{2'b10, 8'h88,  8'h88,  32'd0,        32'h00000080, 1'b0, 32'h00000080, 1'b0};
    vecs[9]  = '{2'b01, 8'hF7,  8'h0F,  32'd0,        32'hFFFFFFF9, 1'b0, 32'hFFFFFFF9, 1'b0};
    vecs[10] = '{2'b00, 8'd127, 8'd127, 32'h7FFFC0FE, 32'h7FFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b0};

    // Reset with busy inputs: everything must come up zero.
    rst_n = 0; enable = 1; quantize_mode = 0; act_in = 8'hAA; act_valid_in = 1;
    psum_in = 32'h1234; weight_load_in = 8'h11; weight_load = 1; weight_swap = 1;
    cycle(); cycle();
    check("rst_psum", ps_s, 0);
    check("rst_vld", {30'd0, pv_s, av_s}, 0);
    check("rst_act", {24'd0, ao_s}, 0);
    check("rst_flags", {30'd0, sf_s, sat_s}, 0);
    rst_n = 1; idle();
    // Active weight is zero after reset.
    apply("rst_w0", 2'b00, 8'd5, 1, 32'd9, 32'd9, 0, 32'd9, 0);

    for (int i = 0; i < 11; i++) begin
      set_weight(vecs[i].w);
      check($sformatf("v%0d_sfull", i), {31'd0, sf_s}, 0);
      apply($sformatf("v%0d", i), vecs[i].mode, vecs[i].act, 1, vecs[i].psum,
            vecs[i].e_sat, vecs[i].f_sat, vecs[i].e_wrap, vecs[i].f_wrap);
    end

    // Pass-through right after an overflowing result clears sat_flag.
    set_weight(8'd127);
    apply("sat_pre", 2'b00, 8'd127, 1, 32'h7FFFFF00, 32'h7FFFFFFF, 1, 32'h80003E01, 1);
    apply("pass42", 2'b00, 8'd3, 0, 32'd42, 32'd42, 0, 32'd42, 0);

    // Double buffer: preload -3 while streaming on weight 2.
    set_weight(8'd2);
    weight_load = 1; weight_load_in = 8'hFD;
    apply("db_stream", 2'b00, 8'd5, 1, 32'd100, 32'd110, 0, 32'd110, 0);
    weight_load = 0;
    check("db_sfull1", {31'd0, sf_s}, 1);
    // Swap on the same edge as compute still uses the old weight.
    weight_swap = 1;
    apply("db_swapedge", 2'b00, 8'd4, 1, 32'd0, 32'd8, 0, 32'd8, 0);
    weight_swap = 0;
    check("db_sfull0", {31'd0, sf_s}, 0);
    apply("db_new", 2'b00, 8'd4, 1, 32'd0, 32'hFFFFFFF4, 0, 32'hFFFFFFF4, 0);

    // Swap while EMPTY is ignored.
    weight_swap = 1; cycle(); weight_swap = 0;
    check("swap_empty_sf", {31'd0, sf_s}, 0);
    apply("swap_empty", 2'b00, 8'd1, 1, 32'd0, 32'hFFFFFFFD, 0, 32'hFFFFFFFD, 0);

    // Load+swap from FULL(5) with new 7.
    weight_load = 1; weight_load_in = 8'd5; cycle();
    weight_swap = 1; weight_load_in = 8'd7; cycle();
    idle();
    check("ls_full_sf", {31'd0, sf_s}, 1);
    apply("ls_active5", 2'b00, 8'd1, 1, 32'd0, 32'd5, 0, 32'd5, 0);
    weight_swap = 1; cycle(); weight_swap = 0;
    apply("ls_shadow7", 2'b00, 8'd1, 1, 32'd0, 32'd7, 0, 32'd7, 0);

    // Load+swap while EMPTY: load wins, swap ignored.
    weight_load = 1; weight_swap = 1; weight_load_in = 8'd9; cycle();
    idle();
    check("ls_empty_sf", {31'd0, sf_s}, 1);
    apply("ls_empty_act", 2'b00, 8'd1, 1, 32'd0, 32'd7, 0, 32'd7, 0);

    // Stall: outputs hold for 3 cycles while weight ops still apply.
    weight_swap = 1; cycle(); weight_swap = 0;
    apply("stall_pre", 2'b00, 8'd2, 1, 32'd1, 32'd19, 0, 32'd19, 0);
    enable = 0; quantize_mode = 2'b00; act_valid_in = 1; act_in = 8'h77; psum_in = 32'h55;
    weight_load = 1; weight_load_in = 8'd3;
    for (int c = 0; c < 3; c++) begin
      cycle();
      weight_load = 0;
      check($sformatf("stall%0d_psum", c), ps_s, last.ps_s);
      check($sformatf("stall%0d_act", c), {24'd0, ao_s}, {24'd0, last.ao});
      check($sformatf("stall%0d_vld", c), {30'd0, pv_s, av_s}, {30'd0, last.pv, last.av});
      check($sformatf("stall%0d_sat", c), {31'd0, sat_s}, {31'd0, last.sf_s});
    end
    check("stall_load_sf", {31'd0, sf_s}, 1);
    enable = 1;

    // Reset mid-stream.
    act_valid_in = 1; act_in = 8'h12; psum_in = 32'h99; rst_n = 0;
    cycle();
    check("mrst_psum", ps_s, 0);
    check("mrst_psum_w", ps_w, 0);
    check("mrst_flags", {27'd0, ao_s == 0 ? 1'b0 : 1'b1, pv_s, av_s, sf_s, sat_s}, 0);
    rst_n = 1; idle();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end
endmodule
